game_sequencer: RTL
===================

# game_sequencer

Top-level game controller for the snake datapath. It owns the game state (idle, running, paused, over) and divides SYS_CLK into game steps. On each step it issues an ordered strobe sequence to the datapath: move the head, evaluate collision and item, then update the body. It also latches player direction input and keeps score and move count. It sits between the button inputs and the move, track, collision and item blocks, and replaces free-running per-block clocking with explicit single-cycle enables.

## Interface
- TICK_DIV, default 5000000: SYS_CLK cycles per game step; legal values are >= 4.
- SYS_CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  start button level; rising edge is detected internally.
- PAUSE  in  1  pause button level; rising edge toggles pause.
- UP, DOWN, LEFT, RIGHT  in  1 each  direction button levels.
- COLLISION  in  1  from the collision block; valid in the EVAL cycle.
- GOT_ITEM  in  1  from the item block; valid in the EVAL cycle.
- DIR  out  2  committed direction: 00 up, 01 down, 10 left, 11 right.
- STEP_MOVE  out  1  one-cycle pulse; the head advances one cell in DIR.
- STEP_TRACK  out  1  one-cycle pulse; body shift.
- GROW  out  1  qualifies STEP_TRACK; when high, length increments.
- ITEM_REGEN  out  1  one-cycle pulse; the item block places a new item.
- GAME_RST  out  1  one-cycle pulse; datapath re-initialises.
- STATE  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 OVER.
- SCORE  out  8  items eaten; saturates at 255.
- MOVES  out  10  completed steps; wraps 1023 -> 0.

## Operation
- Reset values while RST is low:
  - STATE = IDLE, DIR = 11, NEXT_DIR = 11.
  - SCORE = 0, MOVES = 0, tick counter = 0, pause-pending flag = 0.
  - All pulse outputs = 0; edge-detect registers = 0.
- START edge in IDLE or OVER:
  - Next cycle: GAME_RST = 1 and STATE = RUN, phase WAIT.
  - SCORE, MOVES and the tick counter clear; DIR and NEXT_DIR are set to 11.
  - A START edge in RUN or PAUSED is ignored.
- RUN sub-phases: WAIT -> MOVE -> EVAL -> TRACK -> WAIT.
  - WAIT: the tick counter counts 0..TICK_DIV-1 and wraps. Reaching TICK_DIV-1 enters MOVE.
  - MOVE: DIR <= NEXT_DIR and STEP_MOVE = 1 in the same cycle, so the datapath sees the new DIR with the strobe.
  - EVAL: COLLISION and GOT_ITEM are sampled.
    - COLLISION = 1 -> STATE = OVER. No STEP_TRACK, no MOVES increment. COLLISION wins over a simultaneous GOT_ITEM.
    - Otherwise -> TRACK, with the grow flag set to GOT_ITEM.
  - TRACK: STEP_TRACK = 1 and GROW = grow flag; MOVES + 1.
    - If the grow flag is set: ITEM_REGEN = 1 in the same cycle and SCORE + 1, saturating at 255.
- The tick counter keeps counting through MOVE, EVAL and TRACK, so the step period is exactly TICK_DIV cycles.
- Direction latch, active in RUN only:
  - If exactly one button is high, NEXT_DIR takes that direction, unless it is the reverse of the committed DIR (up/down, left/right). A reverse press is ignored.
  - Zero or several buttons high: no change.
  - The last valid press before MOVE wins.
- Pause:
  - A PAUSE edge in WAIT -> PAUSED; the tick counter freezes.
  - A PAUSE edge during MOVE, EVAL or TRACK sets a pending flag. After TRACK the block enters PAUSED instead of WAIT.
  - If the step ends in OVER, the pending flag clears.
  - A PAUSE edge in PAUSED -> RUN WAIT; the counter resumes from its frozen value.
  - PAUSE in IDLE or OVER is ignored.
  - Direction buttons are ignored in PAUSED.
- OVER holds SCORE and MOVES until the next START edge.
- RST asserted mid-step aborts the step immediately; no pending pulse is emitted after release.

## Timing
- All outputs are registered.
- START edge sampled at edge k -> GAME_RST high in cycle k+1.
- First STEP_MOVE is TICK_DIV cycles after the GAME_RST cycle, then one every TICK_DIV cycles.
- STEP_TRACK, GROW and ITEM_REGEN come exactly 2 cycles after STEP_MOVE.
- A collision shows STATE = OVER 2 cycles after STEP_MOVE.
- SCORE and MOVES update in the cycle after the STEP_TRACK edge.
- A button press reaches DIR at the next MOVE cycle, provided it is held at least one cycle before MOVE.

## Test plan
- TICK_DIV = 8, RST low then high, START pulse:
  - GAME_RST one cycle later, STATE = 01.
  - STEP_MOVE every 8 cycles.
  - STEP_TRACK 2 cycles after each STEP_MOVE; MOVES = 3 after 3 steps.
- DIR = 11, LEFT held 3 cycles: ignored, DIR stays 11. Then UP held 3 cycles: DIR = 00 at the next STEP_MOVE.
- GOT_ITEM = 1 in EVAL: GROW = 1 and ITEM_REGEN = 1 with STEP_TRACK; SCORE 0 -> 1. Force 256 eats: SCORE holds at 255.
- COLLISION = 1 and GOT_ITEM = 1 in the same EVAL: STATE = 11, no STEP_TRACK, SCORE unchanged. Then START: SCORE = 0, GAME_RST pulse.
- PAUSE edge in the MOVE cycle: the step completes, then STATE = 10 with no STEP_MOVE for 50 cycles. Second PAUSE edge: the next STEP_MOVE arrives after the remaining counter cycles, not a full 8.
- RST pulled low in the EVAL cycle: STATE = 00 and all pulses 0 immediately. No STEP_TRACK after release.

Source files
------------

// File: rtl/game_sequencer.sv
// Snake game controller: owns the game state, divides the system clock into game steps and
// issues the ordered move / evaluate / track strobes to the datapath, plus direction, score and move count.
module game_sequencer #(
    parameter int TICK_DIV = 5000000
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_collision,
    input  logic       i_got_item,
    output logic [1:0] o_dir,
    output logic       o_step_move,
    output logic       o_step_track,
    output logic       o_grow,
    output logic       o_item_regen,
    output logic       o_game_rst,
    output logic [1:0] o_state,
    output logic [7:0] o_score,
    output logic [9:0] o_moves
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_OVER   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        PH_WAIT  = 2'b00,
        PH_MOVE  = 2'b01,
        PH_EVAL  = 2'b10,
        PH_TRACK = 2'b11
    } phase_t;

    state_t          r_state;
    phase_t          r_phase;
    logic [TW-1:0]   r_tick;
    logic [1:0]      r_dir;
    logic [1:0]      r_next_dir;
    logic [7:0]      r_score;
    logic [9:0]      r_moves;
    logic            r_pause_pend;
    logic            r_start_d;
    logic            r_pause_d;
    logic            r_step_move;
    logic            r_step_track;
    logic            r_grow;
    logic            r_item_regen;
    logic            r_game_rst;

    logic            w_start_edge;
    logic            w_pause_edge;
    logic            w_btn_valid;
    logic [1:0]      w_btn_dir;
    logic            w_btn_ok;

    assign w_start_edge = i_start & ~r_start_d;
    assign w_pause_edge = i_pause & ~r_pause_d;

    // Only a single pressed button names a direction; chords and idle leave NEXT_DIR alone.
    always_comb begin
        w_btn_valid = 1'b1;
        w_btn_dir   = 2'b11;
        case ({i_up, i_down, i_left, i_right})
            4'b1000: w_btn_dir = 2'b00;
            4'b0100: w_btn_dir = 2'b01;
            4'b0010: w_btn_dir = 2'b10;
            4'b0001: w_btn_dir = 2'b11;
            default: w_btn_valid = 1'b0;
        endcase
    end

    // Opposite directions differ only in bit 0 with this encoding.
    assign w_btn_ok = w_btn_valid && ((w_btn_dir ^ r_dir) != 2'b01);

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_phase      <= PH_WAIT;
            r_tick       <= '0;
            r_dir        <= 2'b11;
            r_next_dir   <= 2'b11;
            r_score      <= '0;
            r_moves      <= '0;
            r_pause_pend <= 1'b0;
            r_start_d    <= 1'b0;
            r_pause_d    <= 1'b0;
            r_step_move  <= 1'b0;
            r_step_track <= 1'b0;
            r_grow       <= 1'b0;
            r_item_regen <= 1'b0;
            r_game_rst   <= 1'b0;
        end else begin
            r_start_d    <= i_start;
            r_pause_d    <= i_pause;
            r_step_move  <= 1'b0;
            r_step_track <= 1'b0;
            r_grow       <= 1'b0;
            r_item_regen <= 1'b0;
            r_game_rst   <= 1'b0;

            if (r_state == ST_RUN && w_btn_ok) begin
                r_next_dir <= w_btn_dir;
            end

            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (w_start_edge) begin
                        r_state      <= ST_RUN;
                        r_phase      <= PH_WAIT;
                        r_game_rst   <= 1'b1;
                        r_tick       <= '0;
                        r_score      <= '0;
                        r_moves      <= '0;
                        r_dir        <= 2'b11;
                        r_next_dir   <= 2'b11;
                        r_pause_pend <= 1'b0;
                    end
                end
                ST_RUN: begin
                    case (r_phase)
                        PH_WAIT: begin
                            // A pause seen here freezes the counter at its current value.
                            if (w_pause_edge) begin
                                r_state <= ST_PAUSED;
                            end else if (r_tick == TICK_LAST) begin
                                r_tick      <= '0;
                                r_phase     <= PH_MOVE;
                                r_dir       <= r_next_dir;
                                r_step_move <= 1'b1;
                            end else begin
                                r_tick <= r_tick + TW'(1);
                            end
                        end
                        PH_MOVE: begin
                            r_tick  <= r_tick + TW'(1);
                            r_phase <= PH_EVAL;
                            if (w_pause_edge) r_pause_pend <= 1'b1;
                        end
                        PH_EVAL: begin
                            if (i_collision) begin
                                r_state      <= ST_OVER;
                                r_phase      <= PH_WAIT;
                                r_pause_pend <= 1'b0;
                            end else begin
                                r_tick       <= r_tick + TW'(1);
                                r_phase      <= PH_TRACK;
                                r_step_track <= 1'b1;
                                r_grow       <= i_got_item;
                                r_item_regen <= i_got_item;
                                if (w_pause_edge) r_pause_pend <= 1'b1;
                            end
                        end
                        default: begin
                            // TRACK: r_grow still holds the flag captured in EVAL.
                            r_tick       <= r_tick + TW'(1);
                            r_phase      <= PH_WAIT;
                            r_moves      <= r_moves + 10'd1;
                            if (r_grow && r_score != 8'hFF) r_score <= r_score + 8'd1;
                            if (r_pause_pend || w_pause_edge) r_state <= ST_PAUSED;
                            r_pause_pend <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    if (w_pause_edge) r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign o_dir        = r_dir;
    assign o_step_move  = r_step_move;
    assign o_step_track = r_step_track;
    assign o_grow       = r_grow;
    assign o_item_regen = r_item_regen;
    assign o_game_rst   = r_game_rst;
    assign o_state      = r_state;
    assign o_score      = r_score;
    assign o_moves      = r_moves;

endmodule
